in_port_responder: RTL and testbench
====================================

Name: in_port_responder

Overview:
- Peripheral-side responder for the processor's IN instruction handshake.
- The control unit raises a wait request (its LED output) while an IN instruction is stalled in state 2. It resumes when it samples enter=1.
- This block debounces the physical enter key and captures the board switches into a 32-bit word for the RD mux (flagMUXRD=3). It holds enter until the request drops, so every IN consumes exactly one key press.

Parameters:
- BITS, 32, width of data_in (matches the processor's word width).
- SW_WIDTH, 16, number of board switches; zero-extended to BITS.
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a key level change (5 ms at 50 MHz); minimum 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- req  in  1  wait request from the control unit (its LED output); level, high while IN is waiting.
- key_n  in  1  raw enter pushbutton, active-low, asynchronous to clock.
- switches  in  SW_WIDTH  raw board switches, asynchronous.
- enter  out  1  acknowledge to the control unit; level.
- data_in  out  BITS  captured input word, {zeros, switches}.
- waiting  out  1  board indicator; high in ARMED state only.

Behaviour:
- Reset (reset=0, async): state=IDLE, enter=0, waiting=0, data_in=0, debounced key=released, debounce counter=0, synchronizers=1 for key_n and 0 for switches.
- Synchronization:
  - key_n and switches each pass through 2 flops.
  - The synchronized switch value is the only value ever captured.
- Debounce (key path):
  - Counter clears whenever sync_key equals key_db.
  - Counter increments each cycle while they differ.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, key_db takes sync_key and the counter clears.
  - press_evt is a one-cycle pulse when key_db goes released->pressed. Release produces no event.
  - Glitches shorter than DEBOUNCE_CYCLES never change key_db.
- Latency: if key_n falls before edge E0 and stays low, key_db changes at edge E(1+D) and enter rises at edge E(2+D), where D=DEBOUNCE_CYCLES. With D=4, enter is high after the 6th edge.
- FSM states: IDLE, ARMED, ACK.
  - IDLE: enter=0. Go to ARMED when req=1. press_evt in IDLE is discarded; there is no buffering of early presses.
  - ARMED: waiting=1. On press_evt, capture data_in <= zero-extended sync switches, set enter=1 and go to ACK, all on the same edge. If req drops first (processor reset or abort), return to IDLE with enter=0 and data_in unchanged.
  - ACK: enter held at 1 and data_in frozen until req=0, then go to IDLE with enter=0 on that edge. Further presses are ignored. There is no timeout.
- A key held down across two IN instructions satisfies only the first. The second needs a new release and press (a new press_evt).
- req and press_evt on the same edge in IDLE: go to ARMED, press discarded.
- data_in holds its last captured value between instructions; it changes only on acceptance or reset.
- Reset asserted mid-ACK: enter drops asynchronously. The control unit must be reset together with this block.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, ARMED=1, ACK=2, 2 bits) and the default DEBOUNCE_CYCLES constant.
- Sub-module key_debouncer, parameterised by DEBOUNCE_CYCLES. It contains the 2-flop key synchronizer, the counter and key_db, and outputs key_db and press_evt.
- The top level holds the switch synchronizer, the FSM and the data_in register.

Test Plan (DEBOUNCE_CYCLES=4):
- Basic IN: req=1, switches=16'h00A5, key_n low for 10 cycles -> enter rises exactly 6 edges after key_n falls, data_in=32'h000000A5; then req=0 -> enter=0 on the next edge, state IDLE.
- Bounce rejection: in ARMED, key_n toggles low 3 cycles / high 1 cycle repeatedly, then stays low -> no enter during bouncing; enter rises 6 edges after the final stable fall.
- Early press ignored: key_n pressed and held while req=0, then req=1 -> enter stays 0. Release and re-press -> enter=1 with the switch value present at the re-press.
- Held key across two INs: after the first ACK and req=0, raise req again with the key still held -> enter stays 0 and waiting=1 until release plus a new press.
- Abort: req=1, then req=0 while in ARMED with no press -> waiting=0, enter=0, data_in keeps its previous value (e.g. 32'h000000A5).
- Async reset: assert reset=0 between clock edges during ACK -> enter, waiting and data_in go to 0 immediately. After reset=1 the block sits in IDLE.

Source files
------------

// File: rtl/in_port_responder_pkg.sv
// Shared definitions for the IN-instruction responder: FSM encoding and debounce default.
package in_port_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  // 5 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;

endpackage

// File: rtl/in_port_responder_key_debouncer.sv
// Synchronizes and debounces the active-low enter key; pulses press_evt_o on an accepted press.
module key_debouncer
  import in_port_responder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic key_db_o,
  output logic press_evt_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          key_db_q, key_db_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_key;

  assign sync_key = sync_q[1];

  always_comb begin
    cnt_d    = cnt_q;
    key_db_d = key_db_q;
    press_d  = 1'b0;
    if (sync_key == key_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      // this edge would make the count reach DEBOUNCE_CYCLES: accept the new level
      key_db_d = sync_key;
      cnt_d    = '0;
      press_d  = ~sync_key;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      key_db_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], key_n_i};
      key_db_q <= key_db_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign key_db_o    = key_db_q;
  assign press_evt_o = press_q;

endmodule

// File: rtl/in_port_responder.sv
// IN-instruction responder: answers the control unit's wait request with one debounced key press
// and the synchronized switch word.
module in_port_responder
  import in_port_responder_pkg::*;
#(
  parameter int unsigned BITS            = 32,
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic                key_n,
  input  logic [SW_WIDTH-1:0] switches,
  output logic                enter,
  output logic [BITS-1:0]     data_in,
  output logic                waiting
);

  state_e              state_q, state_d;
  logic [BITS-1:0]     data_q, data_d;
  logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
  logic                key_db;
  logic                press_evt;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .key_n_i    (key_n),
    .key_db_o   (key_db),
    .press_evt_o(press_evt)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (press_evt && !key_db) begin
          data_d  = BITS'(sw_s2_q);
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sw_s1_q <= switches;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign enter   = (state_q == ST_ACK);
  assign waiting = (state_q == ST_ARMED);
  assign data_in = data_q;

endmodule

// File: tb/tb_in_port_responder.sv
// Directed self-checking bench for in_port_responder with a short debounce window.
module tb_in_port_responder;

  logic        clock;
  logic        reset;
  logic        req;
  logic        key_n;
  logic [15:0] switches;
  logic        enter;
  logic [31:0] data_in;
  logic        waiting;

  int unsigned tests_run;
  int unsigned tests_failed;

  in_port_responder #(
    .BITS           (32),
    .SW_WIDTH       (16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .key_n   (key_n),
    .switches(switches),
    .enter   (enter),
    .data_in (data_in),
    .waiting (waiting)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Key falls before the next edge E0; enter must be low through E5 and high after E6.
  task automatic press_and_check(input string tag);
    key_n = 1'b0;
    for (int unsigned i = 0; i <= 6; i++) begin
      tick();
      if (i == 5) check({tag, "_pre"}, 32'(enter), 32'd0);
      if (i == 6) check({tag, "_enter"}, 32'(enter), 32'd1);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    req      = 1'b0;
    key_n    = 1'b1;
    switches = 16'h0000;
    wait_cycles(2);
    check("rst_enter", 32'(enter), 32'd0);
    check("rst_waiting", 32'(waiting), 32'd0);
    check("rst_data", data_in, 32'h0);
    reset = 1'b1;
    tick();

    // basic IN
    switches = 16'h00A5;
    req = 1'b1;
    tick();
    check("basic_waiting", 32'(waiting), 32'd1);
    press_and_check("basic");
    check("basic_data", data_in, 32'h000000A5);
    check("basic_wait_ack", 32'(waiting), 32'd0);
    wait_cycles(3);
    key_n = 1'b1;
    req = 1'b0;
    tick();
    check("basic_drop_enter", 32'(enter), 32'd0);
    check("basic_idle_waiting", 32'(waiting), 32'd0);
    wait_cycles(10);

    // bounce rejection
    switches = 16'h1234;
    req = 1'b1;
    tick();
    for (int unsigned b = 0; b < 3; b++) begin
      key_n = 1'b0;
      for (int unsigned j = 0; j < 3; j++) begin
        tick();
        check("bounce_low", 32'(enter), 32'd0);
      end
      key_n = 1'b1;
      tick();
      check("bounce_high", 32'(enter), 32'd0);
    end
    press_and_check("bounce");
    check("bounce_data", data_in, 32'h00001234);
    key_n = 1'b1;
    req = 1'b0;
    tick();
    wait_cycles(10);

    // early press while idle is discarded
    switches = 16'h4321;
    key_n = 1'b0;
    wait_cycles(10);
    req = 1'b1;
    tick();
    wait_cycles(8);
    check("early_enter", 32'(enter), 32'd0);
    check("early_waiting", 32'(waiting), 32'd1);
    key_n = 1'b1;
    wait_cycles(8);
    check("early_release", 32'(enter), 32'd0);
    switches = 16'hBEEF;
    press_and_check("repress");
    check("repress_data", data_in, 32'h0000BEEF);

    // ACK holds and freezes data; extra switch change ignored
    switches = 16'h7777;
    wait_cycles(4);
    check("ack_hold_enter", 32'(enter), 32'd1);
    check("ack_frozen", data_in, 32'h0000BEEF);

    // key held across two INs
    req = 1'b0;
    tick();
    check("held_drop", 32'(enter), 32'd0);
    req = 1'b1;
    tick();
    wait_cycles(10);
    check("held_enter", 32'(enter), 32'd0);
    check("held_waiting", 32'(waiting), 32'd1);
    key_n = 1'b1;
    wait_cycles(8);
    switches = 16'h00A5;
    press_and_check("held_new");
    check("held_new_data", data_in, 32'h000000A5);
    req = 1'b0;
    tick();
    check("held_new_drop", 32'(enter), 32'd0);
    key_n = 1'b1;
    wait_cycles(10);

    // abort while armed
    switches = 16'hFFFF;
    req = 1'b1;
    tick();
    check("abort_armed", 32'(waiting), 32'd1);
    req = 1'b0;
    tick();
    check("abort_waiting", 32'(waiting), 32'd0);
    check("abort_enter", 32'(enter), 32'd0);
    check("abort_data", data_in, 32'h000000A5);

    // async reset during ACK
    switches = 16'h5A5A;
    req = 1'b1;
    tick();
    press_and_check("rst_ack");
    check("rst_ack_data", data_in, 32'h00005A5A);
    #3;
    reset = 1'b0;
    req   = 1'b0;
    key_n = 1'b1;
    #1;
    check("async_enter", 32'(enter), 32'd0);
    check("async_waiting", 32'(waiting), 32'd0);
    check("async_data", data_in, 32'h0);
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_waiting", 32'(waiting), 32'd0);
    check("post_rst_enter", 32'(enter), 32'd0);
    req = 1'b1;
    tick();
    check("post_rst_armed", 32'(waiting), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
